// File: rtl/qtcore_scan_sequencer_if.sv
// Byte-wide host link of the scan sequencer: image bytes in, readback bytes out.
interface qtcore_scan_sequencer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/qtcore_scan_sequencer.sv
// Host-side scan chain loader, run controller and recirculating readback for the
// accumulator core: IDLE -> LOAD -> RUN -> DUMP -> IDLE.
module qtcore_scan_sequencer #(
    parameter int unsigned  CHAIN_LEN      = 144,
    parameter int unsigned  MAX_RUN_CYCLES = 65535,
    localparam int unsigned RUN_W          = $clog2(MAX_RUN_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    qtcore_scan_sequencer_if.slave host,
    output logic                  scan_enable,
    output logic                  scan_in,
    input  logic                  scan_out,
    output logic                  proc_en,
    input  logic                  halt,
    output logic                  busy,
    output logic                  halted_flag,
    output logic                  timeout_flag,
    output logic [RUN_W-1:0]      run_cycles
);

    localparam int unsigned NBYTES = CHAIN_LEN / 8;
    localparam int unsigned BYTE_W = $clog2(NBYTES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DUMP} state_t;

    state_t             state_q, state_d;
    logic [2:0]         bit_q, bit_d;
    logic [BYTE_W-1:0]  byte_q, byte_d;
    logic [7:0]         sh_q, sh_d;
    logic               scan_en_q, scan_en_d;
    logic               scan_in_q, scan_in_d;
    logic               recirc_q, recirc_d;
    logic               proc_en_q, proc_en_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [7:0]         out_data_q, out_data_d;
    logic               halted_q, halted_d;
    logic               timeout_q, timeout_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic               last_byte;

    assign last_byte = (byte_q == BYTE_W'(NBYTES - 1));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_q       <= '0;
            byte_q      <= '0;
            sh_q        <= '0;
            scan_en_q   <= 1'b0;
            scan_in_q   <= 1'b0;
            recirc_q    <= 1'b0;
            proc_en_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
            run_q       <= '0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            sh_q        <= sh_d;
            scan_en_q   <= scan_en_d;
            scan_in_q   <= scan_in_d;
            recirc_q    <= recirc_d;
            proc_en_q   <= proc_en_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            halted_q    <= halted_d;
            timeout_q   <= timeout_d;
            run_q       <= run_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        sh_d        = sh_q;
        scan_en_d   = scan_en_q;
        scan_in_d   = scan_in_q;
        recirc_d    = recirc_q;
        proc_en_d   = proc_en_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        halted_d    = halted_q;
        timeout_d   = timeout_q;
        run_d       = run_q;

        case (state_q)
            IDLE: begin
                bit_d       = '0;
                byte_d      = '0;
                scan_en_d   = 1'b0;
                scan_in_d   = 1'b0;
                recirc_d    = 1'b0;
                proc_en_d   = 1'b0;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                if (start) begin
                    state_d    = LOAD;
                    halted_d   = 1'b0;
                    timeout_d  = 1'b0;
                    run_d      = '0;
                    in_ready_d = 1'b1;
                end
            end
            LOAD: begin
                if (scan_en_q) begin
                    if (bit_q == 3'd7) begin
                        scan_en_d = 1'b0;
                        bit_d     = '0;
                        if (last_byte) begin
                            state_d    = RUN;
                            byte_d     = '0;
                            in_ready_d = 1'b0;
                            proc_en_d  = 1'b1;
                        end else begin
                            byte_d     = byte_q + BYTE_W'(1);
                            in_ready_d = 1'b1;
                        end
                    end else begin
                        bit_d     = bit_q + 3'd1;
                        scan_in_d = sh_q[6];
                        sh_d      = {sh_q[6:0], 1'b0};
                    end
                end else if (in_ready_q && host.in_valid) begin
                    sh_d       = host.in_data;
                    scan_in_d  = host.in_data[7];
                    scan_en_d  = 1'b1;
                    in_ready_d = 1'b0;
                    bit_d      = '0;
                end
            end
            RUN: begin
                run_d = (run_q == RUN_W'(MAX_RUN_CYCLES)) ? run_q : run_q + RUN_W'(1);
                // Halt has priority over a timeout reached in the same cycle
                if (halt || (run_d == RUN_W'(MAX_RUN_CYCLES))) begin
                    halted_d  = halt;
                    timeout_d = !halt;
                    proc_en_d = 1'b0;
                    state_d   = DUMP;
                    scan_en_d = 1'b1;
                    recirc_d  = 1'b1;
                    bit_d     = '0;
                    byte_d    = '0;
                end
            end
            DUMP: begin
                if (scan_en_q) begin
                    sh_d = {sh_q[6:0], scan_out};
                    if (bit_q == 3'd7) begin
                        scan_en_d   = 1'b0;
                        out_valid_d = 1'b1;
                        out_data_d  = {sh_q[6:0], scan_out};
                        bit_d       = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else if (out_valid_q && host.out_ready) begin
                    out_valid_d = 1'b0;
                    if (last_byte) begin
                        state_d  = IDLE;
                        recirc_d = 1'b0;
                        byte_d   = '0;
                    end else begin
                        byte_d    = byte_q + BYTE_W'(1);
                        scan_en_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort drops any partial byte but keeps the last run's status
        if (abort) begin
            state_d     = IDLE;
            scan_en_d   = 1'b0;
            proc_en_d   = 1'b0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b0;
            recirc_d    = 1'b0;
            bit_d       = '0;
            byte_d      = '0;
            halted_d    = halted_q;
            timeout_d   = timeout_q;
            run_d       = run_q;
        end
    end

    // During readback the chain tail is fed straight back so the image survives the dump
    assign scan_in       = recirc_q ? scan_out : scan_in_q;
    assign scan_enable   = scan_en_q;
    assign proc_en       = proc_en_q;
    assign busy          = (state_q != IDLE);
    assign halted_flag   = halted_q;
    assign timeout_flag  = timeout_q;
    assign run_cycles    = run_q;
    assign host.in_ready  = in_ready_q;
    assign host.out_valid = out_valid_q;
    assign host.out_data  = out_data_q;

endmodule

// File: tb/tb_qtcore_scan_sequencer.sv
// Directed bench for qtcore_scan_sequencer with a behavioural scan chain and a
// byte scoreboard for the readback stream.
module tb_qtcore_scan_sequencer;
    localparam int unsigned CL   = 144;
    localparam int unsigned NB   = CL / 8;
    localparam int unsigned MAXC = 10;
    localparam int unsigned RW   = $clog2(MAXC + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          halt = 1'b0;
    logic          scan_enable, scan_in, scan_out, proc_en;
    logic          busy, halted_flag, timeout_flag;
    logic [RW-1:0] run_cycles;

    qtcore_scan_sequencer_if hif ();

    qtcore_scan_sequencer #(.CHAIN_LEN(CL), .MAX_RUN_CYCLES(MAXC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .host         (hif),
        .scan_enable  (scan_enable),
        .scan_in      (scan_in),
        .scan_out     (scan_out),
        .proc_en      (proc_en),
        .halt         (halt),
        .busy         (busy),
        .halted_flag  (halted_flag),
        .timeout_flag (timeout_flag),
        .run_cycles   (run_cycles)
    );

    always #5 clk = ~clk;

    // Core model: a plain shift chain whose tail drives scan_out
    logic [CL-1:0] chain = '0;
    always @(posedge clk) if (scan_enable) chain <= {chain[CL-2:0], scan_in};
    assign scan_out = chain[CL-1];

    int            n_checks = 0;
    int            n_pass = 0;
    int            n_fail = 0;
    logic [7:0]    exp_q[$];
    logic [7:0]    pat[NB];
    logic [CL-1:0] img = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_chain(input string tag, input logic [CL-1:0] got, input logic [CL-1:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Continuous checks: exclusivity and out_data hold under backpressure
    logic       hold_prev = 1'b0;
    logic [7:0] hold_data = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("excl_scan_proc", 32'(scan_enable && proc_en), 32'(0));
            if (hold_prev) begin
                chk("hold_data", 32'(hif.out_data), 32'(hold_data));
                chk("hold_valid", 32'(hif.out_valid), 32'(1));
            end
        end
        hold_prev = rst_n && hif.out_valid && !hif.out_ready;
        hold_data = hif.out_data;
    end

    task automatic check_zero(input string tag);
        chk({tag, "_se"}, 32'(scan_enable), 32'(0));
        chk({tag, "_sin"}, 32'(scan_in), 32'(0));
        chk({tag, "_pe"}, 32'(proc_en), 32'(0));
        chk({tag, "_ir"}, 32'(hif.in_ready), 32'(0));
        chk({tag, "_ov"}, 32'(hif.out_valid), 32'(0));
        chk({tag, "_od"}, 32'(hif.out_data), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_hf"}, 32'(halted_flag), 32'(0));
        chk({tag, "_tf"}, 32'(timeout_flag), 32'(0));
        chk({tag, "_rc"}, 32'(run_cycles), 32'(0));
    endtask

    task automatic start_seq();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'(1));
        chk("start_in_ready", 32'(hif.in_ready), 32'(1));
        chk("start_hf_clr", 32'(halted_flag), 32'(0));
        chk("start_tf_clr", 32'(timeout_flag), 32'(0));
        chk("start_rc_clr", 32'(run_cycles), 32'(0));
        img = '0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (hif.in_ready) begin
                found = 1'b1;
                break;
            end
        end
        chk("in_ready_wait", 32'(found), 32'(1));
        for (int g = 0; g < gap; g++) begin
            chk("load_stall_se", 32'(scan_enable), 32'(0));
            @(negedge clk);
        end
        hif.in_data  = b;
        hif.in_valid = 1'b1;
        @(negedge clk);
        hif.in_valid = 1'b0;
        chk("first_bit_se", 32'(scan_enable), 32'(1));
        chk("first_bit_val", 32'(scan_in), 32'(b[7]));
        chk("busy_ir_low", 32'(hif.in_ready), 32'(0));
        exp_q.push_back(b);
        img = {img[CL-9:0], b};
    endtask

    task automatic run_phase(input int halt_at, input int exp_cyc, input logic exp_h, input logic exp_t);
        int cnt;
        bit seen;
        cnt  = 0;
        seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (proc_en) begin
                seen = 1'b1;
                cnt++;
                if (halt_at > 0 && cnt == halt_at) halt = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        if (halt_at > 0) halt = 1'b0;
        chk("run_len", 32'(cnt), 32'(exp_cyc));
        chk("halted_flag", 32'(halted_flag), 32'(exp_h));
        chk("timeout_flag", 32'(timeout_flag), 32'(exp_t));
        chk("run_cycles", 32'(run_cycles), 32'(exp_cyc));
    endtask

    task automatic recv_byte(input bit toggle);
        bit got;
        logic [7:0] e;
        got = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (hif.out_valid && hif.out_ready) begin
                chk("sb_nonempty", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("readback", 32'(hif.out_data), 32'(e));
                end
                got = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
            if (toggle && hif.out_valid) chk("dump_stall_se", 32'(scan_enable), 32'(0));
            @(posedge clk);
            #1;
            hif.out_ready = toggle ? ~hif.out_ready : 1'b1;
        end
        chk("out_valid_wait", 32'(got), 32'(1));
    endtask

    task automatic do_seq(input int gap, input bit toggle, input int halt_at,
                          input int exp_cyc, input logic exp_h, input logic exp_t);
        @(posedge clk);
        #1;
        hif.out_ready = 1'b0;
        start_seq();
        for (int i = 0; i < int'(NB); i++) send_byte(pat[i], gap);
        run_phase(halt_at, exp_cyc, exp_h, exp_t);
        for (int i = 0; i < int'(NB); i++) recv_byte(toggle);
        chk("idle_after_dump", 32'(busy), 32'(0));
        chk_chain("chain_recirc", chain, img);
        chk("sb_drained", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        logic [7:0] ab;
        hif.in_data   = '0;
        hif.in_valid  = 1'b0;
        hif.out_ready = 1'b0;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check_zero("por");
        rst_n = 1'b1;

        // Loopback with halt tied high
        for (int i = 0; i < int'(NB); i++) pat[i] = 8'(i);
        halt = 1'b1;
        do_seq(0, 1'b0, 0, 1, 1'b1, 1'b0);

        // Timeout after MAXC cycles
        for (int i = 0; i < int'(NB); i++) pat[i] = 8'(i * 7 + 3);
        halt = 1'b0;
        do_seq(0, 1'b0, -1, int'(MAXC), 1'b0, 1'b1);

        // Halt coinciding with the timeout cycle
        halt = 1'b0;
        do_seq(0, 1'b0, int'(MAXC), int'(MAXC), 1'b1, 1'b0);

        // Backpressure on both sides
        for (int i = 0; i < int'(NB); i++) pat[i] = (i % 2 == 0) ? 8'hA5 : 8'h5A;
        halt = 1'b1;
        do_seq(3, 1'b1, 0, 1, 1'b1, 1'b0);

        // Abort while bit 4 of a byte is being shifted in
        ab = 8'hC3;
        start_seq();
        send_byte(ab, 0);
        repeat (3) @(negedge clk);
        chk("abl_mid_se", 32'(scan_enable), 32'(1));
        chk("abl_mid_bit4", 32'(scan_in), 32'(ab[4]));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abl_busy", 32'(busy), 32'(0));
        chk("abl_se", 32'(scan_enable), 32'(0));
        chk("abl_ir", 32'(hif.in_ready), 32'(0));
        chk("abl_pe", 32'(proc_en), 32'(0));
        exp_q.delete();
        for (int i = 0; i < int'(NB); i++) pat[i] = 8'(8'hF0 ^ 8'(i));
        do_seq(0, 1'b0, 0, 1, 1'b1, 1'b0);

        // Abort mid-readback keeps status
        @(posedge clk);
        #1;
        hif.out_ready = 1'b0;
        start_seq();
        for (int i = 0; i < int'(NB); i++) send_byte(pat[i], 0);
        run_phase(0, 1, 1'b1, 1'b0);
        recv_byte(1'b0);
        recv_byte(1'b0);
        repeat (3) @(negedge clk);
        chk("abd_mid_se", 32'(scan_enable), 32'(1));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abd_busy", 32'(busy), 32'(0));
        chk("abd_se", 32'(scan_enable), 32'(0));
        chk("abd_ov", 32'(hif.out_valid), 32'(0));
        chk("abd_pe", 32'(proc_en), 32'(0));
        chk("abd_hf_kept", 32'(halted_flag), 32'(1));
        chk("abd_rc_kept", 32'(run_cycles), 32'(1));
        exp_q.delete();
        for (int i = 0; i < int'(NB); i++) pat[i] = 8'(8'h3C + 8'(i * 5));
        do_seq(0, 1'b0, 0, 1, 1'b1, 1'b0);

        // Synchronous reset in the middle of a load
        start_seq();
        send_byte(8'h96, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst_mid");
        rst_n = 1'b1;
        exp_q.delete();
        do_seq(0, 1'b0, 0, 1, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
